// File: rtl/round_timer_ctrl.sv
// Round countdown timer: loads a round length, counts whole seconds down in BCD and flags expiry.
// Optional low-time warning output is built only when ROUND_TIMER_WARN_EN is defined.
module round_timer_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRE_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timerEn,
  input  logic       timerReconfig,
  input  logic [1:0] cfgSel,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic       secTick,
  output logic       timeOut,
  output logic       running,
  output logic       warn
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADED  = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  state_t           stateR, stateNextS;
  logic [PRE_W-1:0] preR, preNextS;
  logic [3:0]       tensR, tensNextS;
  logic [3:0]       onesR, onesNextS;
  logic             tickR, tickNextS;
  logic             timeOutR, timeOutNextS;
  logic             runningR, runningNextS;
  logic             preLastS, bcdZeroS, bcdOneS, decS;

  // Round length table in BCD: {tens, ones}
  function automatic logic [7:0] roundLen(input logic [1:0] sel);
    logic [7:0] len;
    case (sel)
      2'd0:    len = 8'h15;
      2'd1:    len = 8'h30;
      2'd2:    len = 8'h45;
      2'd3:    len = 8'h60;
      default: len = 8'h15;
    endcase
    return len;
  endfunction

  assign preLastS = (preR == PRE_LAST);
  assign bcdZeroS = (tensR == 4'd0) && (onesR == 4'd0);
  assign bcdOneS  = (tensR == 4'd0) && (onesR == 4'd1);
  assign decS     = (stateR == RUN) && timerEn && !timerReconfig && preLastS && !bcdZeroS;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state logic; reload beats everything else
  always_comb begin
    stateNextS = stateR;
    if (timerReconfig) begin
      stateNextS = LOADED;
    end else begin
      case (stateR)
        IDLE:    stateNextS = IDLE;
        LOADED:  stateNextS = timerEn ? RUN : LOADED;
        RUN:     stateNextS = (decS && bcdOneS) ? EXPIRED : RUN;
        EXPIRED: stateNextS = EXPIRED;
        default: stateNextS = IDLE;
      endcase
    end
  end

  // Next values for prescaler, BCD count and status outputs
  always_comb begin
    preNextS     = preR;
    tensNextS    = tensR;
    onesNextS    = onesR;
    tickNextS    = 1'b0;
    timeOutNextS = timeOutR;
    if (timerReconfig) begin
      {tensNextS, onesNextS} = roundLen(cfgSel);
      preNextS               = '0;
      timeOutNextS           = 1'b0;
    end else if ((stateR == RUN) && timerEn) begin
      if (preLastS) begin
        preNextS = '0;
        if (!bcdZeroS) begin
          tickNextS = 1'b1;
          if (onesR == 4'd0) begin
            onesNextS = 4'd9;
            tensNextS = tensR - 4'd1;
          end else begin
            onesNextS = onesR - 4'd1;
          end
          timeOutNextS = bcdOneS ? 1'b1 : timeOutR;
        end else begin
          tickNextS = 1'b0;
        end
      end else begin
        preNextS = preR + PRE_W'(1);
      end
    end else begin
      preNextS = preR;
    end
    runningNextS = (stateNextS == RUN) && timerEn;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preR     <= '0;
      tensR    <= 4'd0;
      onesR    <= 4'd0;
      tickR    <= 1'b0;
      timeOutR <= 1'b0;
      runningR <= 1'b0;
    end else begin
      preR     <= preNextS;
      tensR    <= tensNextS;
      onesR    <= onesNextS;
      tickR    <= tickNextS;
      timeOutR <= timeOutNextS;
      runningR <= runningNextS;
    end
  end

`ifdef ROUND_TIMER_WARN_EN
  logic warnR, warnNextS;

  // Warning is live only while counting the last five seconds
  always_comb begin
    warnNextS = (stateNextS == RUN) && (tensNextS == 4'd0) && (onesNextS <= 4'd5);
  end

  // Warning register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warnR <= 1'b0;
    end else begin
      warnR <= warnNextS;
    end
  end

  assign warn = warnR;
`else
  assign warn = 1'b0;
`endif

  assign secTens = tensR;
  assign secOnes = onesR;
  assign secTick = tickR;
  assign timeOut = timeOutR;
  assign running = runningR;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl: directed scenarios plus random traffic against a seconds-level model.
// Define ROUND_TIMER_WARN_EN for both files to exercise the warning output.
module tb_round_timer_ctrl;

  localparam int TPS   = 4;
  localparam int PRE_W = 3;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_EXP  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       timerEn;
  logic       timerReconfig;
  logic [1:0] cfgSel;
  logic [3:0] secTens, secOnes;
  logic       secTick, timeOut, running, warn;

  round_timer_ctrl #(.TICKS_PER_SEC(TPS), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .timerEn(timerEn), .timerReconfig(timerReconfig), .cfgSel(cfgSel),
    .secTens(secTens), .secOnes(secOnes), .secTick(secTick), .timeOut(timeOut),
    .running(running), .warn(warn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: remaining whole seconds and elapsed enabled cycles in the current second
  int mMode = M_IDLE;
  int mRem  = 0;
  int mSub  = 0;
  bit mTick = 1'b0, mTimeOut = 1'b0, mRunning = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit modelWarn();
`ifdef ROUND_TIMER_WARN_EN
    return (mMode == M_RUN) && (mRem <= 5);
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mRem = 0; mSub = 0;
    mTick = 1'b0; mTimeOut = 1'b0; mRunning = 1'b0;
  endtask

  task automatic modelStep(input bit en, input bit rc, input logic [1:0] sel);
    mTick = 1'b0;
    if (rc) begin
      mRem = (int'(sel) + 1) * 15; mSub = 0; mMode = M_LOAD; mTimeOut = 1'b0;
    end else if (mMode == M_LOAD && en) begin
      mMode = M_RUN;
    end else if (mMode == M_RUN && en) begin
      mSub++;
      if (mSub == TPS) begin
        mSub = 0;
        if (mRem > 0) begin
          mRem--; mTick = 1'b1;
          if (mRem == 0) begin
            mTimeOut = 1'b1; mMode = M_EXP;
          end
        end
      end
    end
    mRunning = (mMode == M_RUN) && en;
  endtask

  task automatic compareAll();
    check("secTens", 32'(secTens), 32'(mRem / 10));
    check("secOnes", 32'(secOnes), 32'(mRem % 10));
    check("secTick", 32'(secTick), 32'(mTick));
    check("timeOut", 32'(timeOut), 32'(mTimeOut));
    check("running", 32'(running), 32'(mRunning));
    check("warn",    32'(warn),    32'(modelWarn()));
  endtask

  // One clock: drive at negedge, model the coming edge, compare at the next negedge
  task automatic cycle(input bit en, input bit rc, input logic [1:0] sel);
    timerEn = en; timerReconfig = rc; cfgSel = sel;
    modelStep(en, rc, sel);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    rst = 1'b0; timerEn = 1'b0; timerReconfig = 1'b0; cfgSel = 2'd0;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    rst = 1'b1;

    // IDLE ignores timerEn
    repeat (3) cycle(1'b1, 1'b0, 2'd2);
    check("idle_tens", 32'(secTens), 32'd0);

    // Load 15 s
    cycle(1'b0, 1'b1, 2'd0);
    check("load15_tens", 32'(secTens), 32'd1);
    check("load15_ones", 32'(secOnes), 32'd5);
    check("load15_run",  32'(running), 32'd0);

    // First decrement TPS cycles after RUN entry
    cycle(1'b1, 1'b0, 2'd0);
    check("run_entry", 32'(running), 32'd1);
    repeat (3) cycle(1'b1, 1'b0, 2'd0);
    check("pre_tick", 32'(secTick), 32'd0);
    cycle(1'b1, 1'b0, 2'd0);
    check("first_dec_ones", 32'(secOnes), 32'd4);
    check("first_dec_tick", 32'(secTick), 32'd1);
    cycle(1'b1, 1'b0, 2'd0);
    check("tick_width", 32'(secTick), 32'd0);
    repeat (19) cycle(1'b1, 1'b0, 2'd0);
    check("borrow_tens", 32'(secTens), 32'd0);
    check("borrow_ones", 32'(secOnes), 32'd9);

    // Pause two cycles into a second; resume needs only the remaining two
    repeat (2) cycle(1'b1, 1'b0, 2'd0);
    repeat (10) cycle(1'b0, 1'b0, 2'd0);
    check("pause_ones", 32'(secOnes), 32'd9);
    check("pause_run",  32'(running), 32'd0);
    cycle(1'b1, 1'b0, 2'd0);
    check("resume_hold", 32'(secOnes), 32'd9);
    cycle(1'b1, 1'b0, 2'd0);
    check("resume_dec", 32'(secOnes), 32'd8);

    // Full 15 s round to expiry
    cycle(1'b0, 1'b1, 2'd0);
    cycle(1'b1, 1'b0, 2'd0);
    repeat (59) cycle(1'b1, 1'b0, 2'd0);
    check("pre_expiry_to", 32'(timeOut), 32'd0);
    cycle(1'b1, 1'b0, 2'd0);
    check("expiry_to",   32'(timeOut), 32'd1);
    check("expiry_ones", 32'(secOnes), 32'd0);
    check("expiry_tens", 32'(secTens), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'(i % 2), 1'b0, 2'd0);
    check("expired_hold", 32'(timeOut), 32'd1);
    cycle(1'b0, 1'b1, 2'd3);
    check("load60_tens", 32'(secTens), 32'd6);
    check("load60_to",   32'(timeOut), 32'd0);

    // Reload while counting wins over timerEn
    cycle(1'b1, 1'b0, 2'd3);
    repeat (7) cycle(1'b1, 1'b0, 2'd3);
    cycle(1'b1, 1'b1, 2'd1);
    check("reload_tens", 32'(secTens), 32'd3);
    check("reload_ones", 32'(secOnes), 32'd0);
    check("reload_tick", 32'(secTick), 32'd0);
    repeat (4) cycle(1'b1, 1'b0, 2'd1);

    // Asynchronous reset mid-RUN
    #2 rst = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    compareAll();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
